kf6845_bus_control_logic_multi: RTL and testbench

- Parametrised successor to the CRTC host-bus front end: decodes 6800-style bus cycles (CS_N, RS, ENABLE, R_OR_W) into an address register and one-hot write/read strobes for a configurable register file.
- Adds input synchronisers, access commit on the ENABLE falling edge, per-register access masks, optional address auto-increment and an invalid-access flag.
- Sits between the host bus pins and the CRTC register bank.

---
 rtl/kf6845_bus_control_logic_multi.sv | 146 ++++++++++++++
 tb/tb_kf6845_bus_control_logic_multi.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/kf6845_bus_control_logic_multi.sv
`default_nettype none
// ============================================================================
// Module  : kf6845_bus_control_logic_multi
// Brief   : 6800-style host bus front end for the CRTC register bank.
//           Synchronises the bus pins, commits each access on the falling
//           edge of E and issues one-hot register strobes or an invalid flag.
// Revision: 1.0 - initial release
// ============================================================================
module kf6845_bus_control_logic_multi #(
    parameter int DATA_WIDTH                    = 8,
    parameter int ADDR_WIDTH                    = 5,
    parameter int NUM_REGS                      = 18,
    parameter logic [NUM_REGS-1:0] WRITABLE_MASK = {NUM_REGS{1'b1}},
    parameter logic [NUM_REGS-1:0] READABLE_MASK = NUM_REGS'(18'h3C000),
    parameter int SYNC_STAGES                   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  CS_N,
    input  logic                  RS,
    input  logic                  ENABLE,
    input  logic                  R_OR_W,
    input  logic [DATA_WIDTH-1:0] D_IN,
    input  logic                  auto_increment_enable,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic [ADDR_WIDTH-1:0] address_register,
    output logic [NUM_REGS-1:0]   write_strobe,
    output logic [NUM_REGS-1:0]   read_strobe,
    output logic                  invalid_access
);

    localparam int c_sw = DATA_WIDTH + 4;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_REGS - 1);

    logic [SYNC_STAGES-1:0][c_sw-1:0] r_sync;
    logic [c_sw-1:0]                  w_pins;
    logic                             w_s_cs_n;
    logic                             w_s_rs;
    logic                             w_s_enable;
    logic                             w_s_r_or_w;
    logic [DATA_WIDTH-1:0]            w_s_data;

    logic                             r_enable_d;
    logic                             r_pending;
    logic                             r_cap_rs;
    logic                             r_cap_r_or_w;
    logic [DATA_WIDTH-1:0]            r_cap_data;

    logic                             w_commit;
    logic [NUM_REGS-1:0]              w_onehot;
    logic                             w_write_ok;
    logic                             w_read_ok;
    logic [ADDR_WIDTH-1:0]            w_addr_next;

    assign w_pins = {CS_N, RS, ENABLE, R_OR_W, D_IN};
    assign {w_s_cs_n, w_s_rs, w_s_enable, w_s_r_or_w, w_s_data} = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Capture keeps the last values seen while E is high so that CS_N may
    // rise in the same clock as E falls without losing the access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_enable_d   <= 1'b0;
            r_pending    <= 1'b0;
            r_cap_rs     <= 1'b0;
            r_cap_r_or_w <= 1'b0;
            r_cap_data   <= '0;
        end else begin
            r_enable_d <= w_s_enable;
            if (w_s_enable && !w_s_cs_n) begin
                r_pending    <= 1'b1;
                r_cap_rs     <= w_s_rs;
                r_cap_r_or_w <= w_s_r_or_w;
                r_cap_data   <= w_s_data;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_commit = r_enable_d && !w_s_enable && r_pending;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_onehot[i] = (address_register == ADDR_WIDTH'(i));
        end
    end

    // Addresses at or beyond NUM_REGS never match w_onehot, so they fail both checks.
    assign w_write_ok  = |(w_onehot & WRITABLE_MASK);
    assign w_read_ok   = |(w_onehot & READABLE_MASK);
    assign w_addr_next = (address_register >= c_last_addr) ? '0
                                                           : address_register + ADDR_WIDTH'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            internal_data_bus <= '0;
            address_register  <= '0;
            write_strobe      <= '0;
            read_strobe       <= '0;
            invalid_access    <= 1'b0;
        end else begin
            write_strobe   <= '0;
            read_strobe    <= '0;
            invalid_access <= 1'b0;
            if (w_commit) begin
                if (!r_cap_rs) begin
                    if (!r_cap_r_or_w) begin
                        address_register <= r_cap_data[ADDR_WIDTH-1:0];
                    end
                end else begin
                    if (!r_cap_r_or_w) begin
                        if (w_write_ok) begin
                            write_strobe      <= w_onehot;
                            internal_data_bus <= r_cap_data;
                        end else begin
                            invalid_access <= 1'b1;
                        end
                    end else begin
                        if (w_read_ok) begin
                            read_strobe <= w_onehot;
                        end else begin
                            invalid_access <= 1'b1;
                        end
                    end
                    if (auto_increment_enable) begin
                        address_register <= w_addr_next;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kf6845_bus_control_logic_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_kf6845_bus_control_logic_multi
// Brief   : Directed self-checking bench for the CRTC host bus front end.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kf6845_bus_control_logic_multi;

    logic        clock;
    logic        reset_n;
    logic        CS_N;
    logic        RS;
    logic        ENABLE;
    logic        R_OR_W;
    logic [7:0]  D_IN;
    logic        auto_increment_enable;
    logic [7:0]  internal_data_bus;
    logic [4:0]  address_register;
    logic [17:0] write_strobe;
    logic [17:0] read_strobe;
    logic        invalid_access;

    int n_checks = 0;
    int n_pass   = 0;

    kf6845_bus_control_logic_multi dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .CS_N                  (CS_N),
        .RS                    (RS),
        .ENABLE                (ENABLE),
        .R_OR_W                (R_OR_W),
        .D_IN                  (D_IN),
        .auto_increment_enable (auto_increment_enable),
        .internal_data_bus     (internal_data_bus),
        .address_register      (address_register),
        .write_strobe          (write_strobe),
        .read_strobe           (read_strobe),
        .invalid_access        (invalid_access)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse vector layout: {write_strobe[17:0], read_strobe[17:0], invalid_access}
    function automatic logic [36:0] ws(input int i);
        return 37'(1) << (19 + i);
    endfunction
    function automatic logic [36:0] rs(input int i);
        return 37'(1) << (1 + i);
    endfunction
    localparam logic [36:0] INV  = 37'd1;
    localparam logic [36:0] NONE = 37'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // E high for two clocks; E and CS_N drop together, then pulses are
    // expected only on the third clock after the fall.
    task automatic access(input logic rs_i, input logic rw_i, input logic [7:0] data,
                          input logic cs_active, input logic [36:0] exp, input string tag);
        @(posedge clock); #1;
        CS_N   = !cs_active;
        RS     = rs_i;
        R_OR_W = rw_i;
        D_IN   = data;
        ENABLE = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        ENABLE = 1'b0;
        CS_N   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
            chk($sformatf("%s_c%0d", tag, c),
                64'({write_strobe, read_strobe, invalid_access}),
                64'((c == 3) ? exp : NONE));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        CS_N = 1'b1; RS = 1'b0; ENABLE = 1'b0; R_OR_W = 1'b1; D_IN = 8'h00;
        auto_increment_enable = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_idb",  64'(internal_data_bus), 64'h0);
        chk("rst_addr", 64'(address_register),  64'h0);
        chk("rst_ws",   64'(write_strobe),      64'h0);
        chk("rst_rs",   64'(read_strobe),       64'h0);
        chk("rst_inv",  64'(invalid_access),    64'h0);
        reset_n = 1'b1;

        access(1'b0, 1'b0, 8'h03, 1'b1, NONE, "addr3");
        chk("addr_is_3", 64'(address_register), 64'h3);
        access(1'b1, 1'b0, 8'h55, 1'b1, ws(3), "wr_r3");
        chk("idb_55", 64'(internal_data_bus), 64'h55);

        access(1'b0, 1'b0, 8'h0E, 1'b1, NONE, "addr14");
        access(1'b1, 1'b1, 8'h00, 1'b1, rs(14), "rd_r14");
        access(1'b0, 1'b0, 8'h05, 1'b1, NONE, "addr5");
        access(1'b1, 1'b1, 8'h00, 1'b1, INV, "rd_r5_inv");

        access(1'b0, 1'b0, 8'h12, 1'b1, NONE, "addr18");
        access(1'b1, 1'b0, 8'hAA, 1'b1, INV, "wr_r18_inv");
        chk("idb_keep_55", 64'(internal_data_bus), 64'h55);
        chk("addr_stay_18", 64'(address_register), 64'h12);

        auto_increment_enable = 1'b1;
        access(1'b0, 1'b0, 8'h14, 1'b1, NONE, "addr20");
        access(1'b1, 1'b1, 8'h00, 1'b1, INV, "rd_r20_inv");
        chk("wrap_from_20", 64'(address_register), 64'h0);
        access(1'b0, 1'b0, 8'h10, 1'b1, NONE, "addr16");
        chk("auto_rs0_no_inc", 64'(address_register), 64'h10);
        access(1'b1, 1'b0, 8'h11, 1'b1, ws(16), "ai_r16");
        chk("ai_addr17", 64'(address_register), 64'h11);
        access(1'b1, 1'b0, 8'h22, 1'b1, ws(17), "ai_r17");
        chk("ai_addr0", 64'(address_register), 64'h0);
        access(1'b1, 1'b0, 8'h33, 1'b1, ws(0), "ai_r0");
        chk("ai_addr1", 64'(address_register), 64'h1);
        chk("idb_33", 64'(internal_data_bus), 64'h33);
        auto_increment_enable = 1'b0;

        access(1'b0, 1'b0, 8'h02, 1'b1, NONE, "addr2");
        access(1'b1, 1'b0, 8'h7E, 1'b1, ws(2), "wr_r2_csrise");
        chk("idb_7e", 64'(internal_data_bus), 64'h7E);
        access(1'b1, 1'b0, 8'hC3, 1'b0, NONE, "cs_high");
        chk("cs_high_idb",  64'(internal_data_bus), 64'h7E);
        chk("cs_high_addr", 64'(address_register),  64'h2);

        access(1'b0, 1'b0, 8'h05, 1'b1, NONE, "addr5b");
        @(posedge clock); #1;
        CS_N = 1'b0; RS = 1'b1; R_OR_W = 1'b0; D_IN = 8'h99; ENABLE = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", 64'(address_register),  64'h0);
        chk("mid_rst_idb",  64'(internal_data_bus), 64'h0);
        @(posedge clock); #1;
        ENABLE = 1'b0; CS_N = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock); #1;
            chk($sformatf("post_rst_c%0d", c),
                64'({write_strobe, read_strobe, invalid_access}), 64'(NONE));
        end
        chk("post_rst_addr", 64'(address_register),  64'h0);
        chk("post_rst_idb",  64'(internal_data_bus), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
